// File: rtl/scan_hex_pkg.sv
// Shared encodings for the debug-unit receive-side scanner.
package scan_hex_pkg;

  typedef enum logic [1:0] {
    SCAN_IDLE = 2'd0,
    SCAN_BYTE = 2'd1,
    SCAN_WORD = 2'd2,
    SCAN_DONE = 2'd3
  } scan_state_t;

  localparam logic [7:0] CH_US = 8'h5F;
  localparam logic [7:0] CH_BS = 8'h08;
  localparam logic [7:0] CH_SP = 8'h20;
  localparam logic [7:0] CH_CR = 8'h0D;
  localparam logic [7:0] CH_LF = 8'h0A;

endpackage

// File: rtl/scan_hex_c2h_nibble.sv
// ASCII hex digit decoder: '0'-'9', 'A'-'F', 'a'-'f' -> nibble value.
module c2h_nibble (
  input  logic [7:0] i_ch,
  output logic       o_is_hex,
  output logic [3:0] o_nib
);

  always_comb begin
    o_is_hex = 1'b1;
    o_nib    = 4'h0;
    if (i_ch >= 8'h30 && i_ch <= 8'h39)      o_nib = 4'(i_ch - 8'h30);
    else if (i_ch >= 8'h41 && i_ch <= 8'h46) o_nib = 4'(i_ch - 8'h37);
    else if (i_ch >= 8'h61 && i_ch <= 8'h66) o_nib = 4'(i_ch - 8'h57);
    else                                     o_is_hex = 1'b0;
  end

endmodule

// File: rtl/scan_hex.sv
// Parses rx characters into a raw byte or a hex word for the DCP.
// SCAN_ECHO_EN adds echo_vld/echo_d, re-emitting accepted characters.
module scan_hex
  import scan_hex_pkg::*;
#(
  parameter int MAX_DIGITS = 8,
  parameter int DIN_W      = 32
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             req_rx,
  input  logic             type_rx,
  input  logic             vld_rx,
  input  logic [7:0]       d_rx,
  output logic [DIN_W-1:0] din_rx,
  output logic             err_rx,
  output logic             ack_rx
`ifdef SCAN_ECHO_EN
  ,
  output logic             echo_vld,
  output logic [7:0]       echo_d
`endif
);

  // Digits beyond MAX_DIGITS fall off the top of the accumulator.
  localparam logic [DIN_W-1:0] ACC_MASK = (4*MAX_DIGITS >= DIN_W) ? {DIN_W{1'b1}}
                                        : ((DIN_W'(1) << (4*MAX_DIGITS)) - DIN_W'(1));
  localparam logic [3:0]       MAXD     = 4'(MAX_DIGITS);

  scan_state_t      r_state, w_state_n;
  logic [DIN_W-1:0] r_acc, w_acc_n, r_din, w_din_n;
  logic [3:0]       r_cnt, w_cnt_n;
  logic             r_err, w_err_n, r_ack, w_ack_n;
  logic             r_req_q, r_req_d, r_type_q, w_req_edge;
  logic             w_is_hex, w_ws;
  logic [3:0]       w_nib;

  c2h_nibble u_c2h (.i_ch(d_rx), .o_is_hex(w_is_hex), .o_nib(w_nib));

  assign w_req_edge = r_req_q & ~r_req_d;
  assign w_ws       = (d_rx == CH_SP) || (d_rx == CH_CR) || (d_rx == CH_LF);

  always_comb begin
    w_state_n = r_state;
    w_acc_n   = r_acc;
    w_cnt_n   = r_cnt;
    w_din_n   = r_din;
    w_err_n   = r_err;
    w_ack_n   = 1'b0;
    case (r_state)
      SCAN_IDLE: if (w_req_edge) begin
        w_acc_n   = '0;
        w_cnt_n   = '0;
        w_err_n   = 1'b0;
        w_state_n = r_type_q ? SCAN_WORD : SCAN_BYTE;
      end
      SCAN_BYTE: if (vld_rx) begin
        w_din_n   = DIN_W'(d_rx);
        w_state_n = SCAN_DONE;
      end
      SCAN_WORD: if (vld_rx) begin
        if (w_is_hex) begin
          w_acc_n = {r_acc[DIN_W-5:0], w_nib} & ACC_MASK;
          if (r_cnt < MAXD) w_cnt_n = r_cnt + 4'd1;
        end else if (d_rx == CH_BS) begin
          if (r_cnt != 4'd0) begin
            w_acc_n = r_acc >> 4;
            w_cnt_n = r_cnt - 4'd1;
          end
        end else if (w_ws) begin
          if (r_cnt != 4'd0) begin
            w_din_n   = r_acc;
            w_err_n   = 1'b0;
            w_state_n = SCAN_DONE;
          end
        end else if (d_rx != CH_US) begin
          w_din_n   = r_acc;
          w_err_n   = 1'b1;
          w_state_n = SCAN_DONE;
        end
      end
      SCAN_DONE: begin
        w_ack_n   = 1'b1;
        w_state_n = SCAN_IDLE;
      end
      default: w_state_n = SCAN_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_state  <= SCAN_IDLE;
      r_acc    <= '0;
      r_cnt    <= '0;
      r_din    <= '0;
      r_err    <= 1'b0;
      r_ack    <= 1'b0;
      r_req_q  <= 1'b0;
      r_req_d  <= 1'b0;
      r_type_q <= 1'b0;
    end else begin
      r_state  <= w_state_n;
      r_acc    <= w_acc_n;
      r_cnt    <= w_cnt_n;
      r_din    <= w_din_n;
      r_err    <= w_err_n;
      r_ack    <= w_ack_n;
      r_req_q  <= req_rx;
      r_req_d  <= r_req_q;
      r_type_q <= type_rx;
    end
  end

  assign din_rx = r_din;
  assign err_rx = r_err;
  assign ack_rx = r_ack;

`ifdef SCAN_ECHO_EN
  logic       r_echo_vld;
  logic [7:0] r_echo_d;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_echo_vld <= 1'b0;
      r_echo_d   <= 8'h00;
    end else begin
      r_echo_vld <= vld_rx && (r_state == SCAN_BYTE || r_state == SCAN_WORD);
      r_echo_d   <= d_rx;
    end
  end

  assign echo_vld = r_echo_vld;
  assign echo_d   = r_echo_d;
`endif

endmodule

// File: doc/scan_hex.md
Name: scan_hex

Overview:
- Receive-side counterpart of the debug unit's print path.
- Takes ASCII characters from the serial receiver and parses them for the debug control processor (DCP): either one raw byte, or a hexadecimal word typed by the user.
- Handshake to DCP: request rising edge in, one-cycle acknowledge out.
- Sits between the UART rx module and the DCP.

Parameters:
- MAX_DIGITS, 8: hex digits retained in the accumulator; 1..8; older digits shift out.
- DIN_W, 32: width of the parsed result.

Ports:
- clk  input  1  system clock.
- rstn  input  1  asynchronous active-low reset.
- req_rx  input  1  request to scan (from DCP); level signal, rising edge starts a scan.
- type_rx  input  1  0 = Byte, 1 = Word (from DCP); sampled on the req_rx rising edge.
- vld_rx  input  1  character valid, one-cycle pulse (from rx).
- d_rx  input  8  received character (from rx); valid with vld_rx.
- din_rx  output  DIN_W  parsed data (to DCP); held until next scan starts.
- err_rx  output  1  1 = word scan ended on an illegal character; held with din_rx.
- ack_rx  output  1  scan complete, one-cycle pulse (to DCP).

Behaviour:
- Reset (async, rstn=0): state SCAN_IDLE; din_rx=0; err_rx=0; ack_rx=0; digit count=0. Reset mid-scan aborts with no ack.
- req_rx rising edge: detected internally, one cycle after the 0->1 transition is sampled. Edges while not in SCAN_IDLE are ignored.
- SCAN_IDLE:
  - vld_rx is dropped.
  - On a req edge: clear accumulator, count and err_rx; go to SCAN_BYTE if type_rx=0, else SCAN_WORD.
- SCAN_BYTE: first vld_rx -> din_rx = {24'b0, d_rx}; go to SCAN_DONE.
- SCAN_WORD, per vld_rx character:
  - '0'-'9', 'A'-'F', 'a'-'f': acc = {acc[DIN_W-5:0], nibble}; count = min(count+1, MAX_DIGITS).
  - With MAX_DIGITS<8, bits above 4*MAX_DIGITS are forced 0.
  - '_' (0x5F): ignored anywhere (matches print separator).
  - Backspace 0x08: if count>0, acc = acc>>4 and count-1; else ignored.
  - Space 0x20, CR 0x0D, LF 0x0A: if count==0, skipped as leading whitespace; else din_rx=acc, err_rx=0, go to SCAN_DONE.
  - Any other character: din_rx=acc, err_rx=1, go to SCAN_DONE.
- SCAN_DONE: ack_rx=1 for exactly one cycle; return to SCAN_IDLE.
- Latency: ack_rx asserted 2 cycles after the terminating vld_rx cycle. din_rx/err_rx are stable from the first ack cycle onward.
- vld_rx arriving in SCAN_DONE is dropped. DCP must not re-request before ack.
- Back-to-back characters on consecutive cycles must all be accepted.

Optional Feature:
- Macro SCAN_ECHO_EN.
- Defined:
  - Adds outputs echo_vld (1) and echo_d (8).
  - Every character accepted in SCAN_BYTE/SCAN_WORD, including skipped whitespace, '_' and backspace, is echoed one cycle later as a one-cycle echo_vld pulse.
  - Characters dropped in SCAN_IDLE/SCAN_DONE are not echoed.
  - Echo logic does not stall parsing.
- Undefined: ports absent, no echo logic.

Decomposition:
- Shared package holds:
  - state encodings SCAN_IDLE=0, SCAN_BYTE=1, SCAN_WORD=2, SCAN_DONE=3;
  - character constants CH_US=8'h5F, CH_BS=8'h08, CH_SP=8'h20, CH_CR=8'h0D, CH_LF=8'h0A.
- One sub-module: c2h_nibble, combinational ASCII->{is_hex, nibble[3:0]} decoder.
- The req edge detector is a few lines inline.

Test Plan:
- Byte: req_rx rise, type_rx=0; send 'Q'(0x51) -> ack pulse, din_rx=0x00000051, err_rx=0.
- Word: type_rx=1; send "1234_abCD\r" -> din_rx=0x1234ABCD, err_rx=0, one ack pulse 2 cycles after CR.
- Leading whitespace and overflow: send " \n123456789A " -> din_rx=0x3456789A, err_rx=0.
- Backspace and illegal char:
  - send "12F",0x08,"5\r" -> din_rx=0x125;
  - then a new request with "7G" -> din_rx=0x7, err_rx=1.
- Reset mid-scan and ignored traffic:
  - vld_rx in SCAN_IDLE -> no ack;
  - after "AB", rstn=0 -> din_rx=0, no ack;
  - req edge during scan -> ignored.
- With SCAN_ECHO_EN: "A_\r" -> echo_vld pulses with 0x41, 0x5F, 0x0D, each one cycle after its vld_rx.
